// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: Avalon-MM master that programs an interval-timer slave,
// services its timeout interrupts and optionally stops it on request.
// Optional feature: define TIMER_CTRL_MASTER_SNAPSHOT_EN to add a snapshot
// sequence that latches the slave's running counter into snap_value.
module timer_ctrl_master #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      period,
    input  logic             continuous,
    output logic [2:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [15:0]      writedata,
    input  logic [15:0]      readdata,
    input  logic             irq,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [CNT_W-1:0] tick_count
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
    ,
    input  logic             snap_req,
    output logic [31:0]      snap_value,
    output logic             snap_valid
`endif
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        WAIT_IRQ,
        CLR_STAT,
        WR_STOP,
        CLR_STOP
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
        ,
        SNAP_WR,
        SNAP_RD_LO,
        SNAP_RD_HI,
        SNAP_CAP
`endif
    } state_e;

    state_e      state_q;
    logic [15:0] per_hi_q;   // upper half of period, written one cycle after the lower half
    logic        cont_q;     // periodic/one-shot mode latched at start

`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
    logic [15:0] snap_lo_q;
`else
    // readdata is only consumed by the snapshot sequence
    logic unused_rd;
    assign unused_rd = ^readdata;
`endif

    // Single FSM; every output is registered and reflects the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            address    <= 3'd0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= 16'h0000;
            busy       <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
            tick_count <= '0;
            per_hi_q   <= 16'h0000;
            cont_q     <= 1'b0;
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
            snap_lo_q  <= 16'h0000;
            snap_value <= 32'h0;
            snap_valid <= 1'b0;
`endif
        end else begin
            // pulses and the bus default to idle each cycle
            tick       <= 1'b0;
            done       <= 1'b0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= 3'd0;
            writedata  <= 16'h0000;
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
            snap_valid <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        per_hi_q   <= period[31:16];
                        cont_q     <= continuous;
                        tick_count <= '0;
                        busy       <= 1'b1;
                        chipselect <= 1'b1;
                        write_n    <= 1'b0;
                        address    <= 3'd2;
                        writedata  <= period[15:0];
                        state_q    <= WR_PL;
                    end
                end
                WR_PL: begin
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    address    <= 3'd3;
                    writedata  <= per_hi_q;
                    state_q    <= WR_PH;
                end
                WR_PH: begin
                    // control: START | CONT (mode) | ITO
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    address    <= 3'd1;
                    writedata  <= {13'd0, 1'b1, cont_q, 1'b1};
                    state_q    <= WR_CTRL;
                end
                WR_CTRL: begin
                    state_q <= WAIT_IRQ;
                end
                WAIT_IRQ: begin
                    if (stop) begin
                        // stop wins over a coincident irq; no tick for it
                        chipselect <= 1'b1;
                        write_n    <= 1'b0;
                        address    <= 3'd1;
                        writedata  <= 16'h0008;
                        state_q    <= WR_STOP;
                    end else if (irq) begin
                        chipselect <= 1'b1;
                        write_n    <= 1'b0;
                        address    <= 3'd0;
                        writedata  <= 16'h0000;
                        tick       <= 1'b1;
                        tick_count <= tick_count + 1'b1;
                        state_q    <= CLR_STAT;
                    end
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
                    else if (snap_req) begin
                        // writing snapl freezes the counter into the snap registers
                        chipselect <= 1'b1;
                        write_n    <= 1'b0;
                        address    <= 3'd4;
                        writedata  <= 16'h0000;
                        state_q    <= SNAP_WR;
                    end
`endif
                end
                CLR_STAT: begin
                    if (cont_q) begin
                        state_q <= WAIT_IRQ;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WR_STOP: begin
                    chipselect <= 1'b1;
                    write_n    <= 1'b0;
                    address    <= 3'd0;
                    writedata  <= 16'h0000;
                    state_q    <= CLR_STOP;
                end
                CLR_STOP: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= IDLE;
                end
`ifdef TIMER_CTRL_MASTER_SNAPSHOT_EN
                // irq is not looked at until WAIT_IRQ is re-entered; the slave holds it
                SNAP_WR: begin
                    chipselect <= 1'b1;
                    address    <= 3'd4;
                    state_q    <= SNAP_RD_LO;
                end
                SNAP_RD_LO: begin
                    chipselect <= 1'b1;
                    address    <= 3'd5;
                    state_q    <= SNAP_RD_HI;
                end
                SNAP_RD_HI: begin
                    // readdata now carries the low half requested last cycle
                    snap_lo_q <= readdata;
                    state_q   <= SNAP_CAP;
                end
                SNAP_CAP: begin
                    snap_value <= {readdata, snap_lo_q};
                    snap_valid <= 1'b1;
                    state_q    <= WAIT_IRQ;
                end
`endif
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
